// File: rtl/asg_seq_player.sv
// Multi-segment waveform sequencer for one ASG DAC channel: walks a list of
// RAM windows with fractional steps, then scales and offsets each sample.
`timescale 1ns/1ps

module asg_seq_player #(
    parameter int NSEG   = 4,
    parameter int DAC_DW = 14,
    parameter int RSZ    = 14,
    parameter int FRAC   = 16,
    parameter int CW     = 16,
    localparam int SW    = $clog2(NSEG)
) (
    input  logic              dac_clk_i,
    input  logic              dac_rstn_i,
    input  logic              arm_i,
    input  logic              stop_i,
    input  logic              trig_i,
    input  logic              loop_i,
    input  logic [SW-1:0]     seq_last_i,
    input  logic              cfg_we_i,
    input  logic [SW-1:0]     cfg_seg_i,
    input  logic [2:0]        cfg_field_i,
    input  logic [31:0]       cfg_data_i,
    output logic [RSZ-1:0]    buf_addr_o,
    input  logic [DAC_DW-1:0] buf_rdata_i,
    output logic [DAC_DW-1:0] dac_o,
    output logic              busy_o,
    output logic [SW-1:0]     seg_o,
    output logic              done_o
);
    localparam int PW   = RSZ + FRAC + 1;
    localparam int SUMW = DAC_DW + 3;

    typedef enum logic [1:0] {IDLE, ARMED, RUN, DONE} state_t;
    state_t state, state_next;

    logic        [RSZ-1:0]      dsc_start  [NSEG];
    logic        [RSZ-1:0]      dsc_end    [NSEG];
    logic        [RSZ+FRAC-1:0] dsc_step   [NSEG];
    logic        [CW-1:0]       dsc_cycles [NSEG];
    logic        [DAC_DW-1:0]   dsc_amp    [NSEG];
    logic signed [DAC_DW-1:0]   dsc_off    [NSEG];

    logic [RSZ-1:0]      act_start, act_end, end_eff;
    logic [RSZ+FRAC-1:0] act_step;
    logic [DAC_DW-1:0]   act_amp;
    logic signed [DAC_DW-1:0] act_off;
    logic [CW-1:0]       cnt;
    logic [SW-1:0]       seg, entry_seg;
    logic [PW-1:0]       ptr, p_next;
    logic trig_q, trig_rise, wrap, seg_done, last_seg, seq_end, entry, run_next;
    logic cfg_unused;

    logic                     vld_p0, vld_p1;
    logic [DAC_DW-1:0]        amp_p0;
    logic signed [DAC_DW-1:0] off_p0, off_p1;
    logic signed [DAC_DW+1:0] prod_p1;
    logic signed [SUMW-1:0]   sum_p1;
    logic signed [DAC_DW-1:0] dac_p2;
    logic                     done_q;

    function automatic logic signed [DAC_DW+1:0] scale(input logic signed [DAC_DW-1:0] smp,
                                                       input logic [DAC_DW-1:0] amp);
        logic signed [2*DAC_DW:0] prod;
        prod = (2*DAC_DW+1)'(smp) * $signed({{(DAC_DW+1){1'b0}}, amp});
        return prod[2*DAC_DW:DAC_DW-1];
    endfunction

    function automatic logic signed [DAC_DW-1:0] sat(input logic signed [SUMW-1:0] x);
        logic [SUMW-DAC_DW:0] top;
        logic signed [DAC_DW-1:0] r;
        top = x[SUMW-1:DAC_DW-1];
        if (top == '0 || top == '1)
            r = x[DAC_DW-1:0];
        else if (x[SUMW-1])
            r = {1'b1, {(DAC_DW-1){1'b0}}};
        else
            r = {1'b0, {(DAC_DW-1){1'b1}}};
        return r;
    endfunction

    assign cfg_unused = ^cfg_data_i;

    always_ff @(posedge dac_clk_i or negedge dac_rstn_i) begin
        if (!dac_rstn_i) begin
            for (int i = 0; i < NSEG; i++) begin
                dsc_start[i]  <= '0;
                dsc_end[i]    <= '0;
                dsc_step[i]   <= '0;
                dsc_cycles[i] <= '0;
                dsc_amp[i]    <= '0;
                dsc_off[i]    <= '0;
            end
        end else if (cfg_we_i) begin
            case (cfg_field_i)
                3'd0:    dsc_start[cfg_seg_i]  <= cfg_data_i[RSZ-1:0];
                3'd1:    dsc_end[cfg_seg_i]    <= cfg_data_i[RSZ-1:0];
                3'd2:    dsc_step[cfg_seg_i]   <= cfg_data_i[RSZ+FRAC-1:0];
                3'd3:    dsc_cycles[cfg_seg_i] <= cfg_data_i[CW-1:0];
                3'd4:    dsc_amp[cfg_seg_i]    <= cfg_data_i[DAC_DW-1:0];
                3'd5:    dsc_off[cfg_seg_i]    <= cfg_data_i[DAC_DW-1:0];
                default: ;
            endcase
        end
    end

    // A window completes when the next pointer leaves [start, end] or carries out.
    assign trig_rise = trig_i & ~trig_q;
    assign end_eff   = (act_end < act_start) ? act_start : act_end;
    assign p_next    = ptr + {1'b0, act_step};
    assign wrap      = p_next[PW-1] || (p_next[FRAC +: RSZ] > end_eff);
    assign seg_done  = wrap && (cnt <= CW'(1));
    assign last_seg  = (seg >= seq_last_i);
    assign seq_end   = seg_done && last_seg && !loop_i;
    assign run_next  = (state_next == RUN);
    assign entry     = run_next && ((state != RUN) || seg_done);
    assign entry_seg = ((state != RUN) || last_seg) ? '0 : seg + 1'b1;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (arm_i) state_next = ARMED;
            ARMED:   if (trig_rise) state_next = RUN;
            RUN:     if (seq_end) state_next = DONE;
            DONE:    if (arm_i) state_next = ARMED;
            default: state_next = IDLE;
        endcase
        if (stop_i) state_next = IDLE;
    end

    always_ff @(posedge dac_clk_i or negedge dac_rstn_i) begin
        if (!dac_rstn_i) begin
            state     <= IDLE;
            trig_q    <= 1'b0;
            seg       <= '0;
            ptr       <= '0;
            cnt       <= '0;
            act_start <= '0;
            act_end   <= '0;
            act_step  <= '0;
            done_q    <= 1'b0;
            vld_p0    <= 1'b0;
            vld_p1    <= 1'b0;
            dac_p2    <= '0;
        end else begin
            state  <= state_next;
            trig_q <= trig_i;
            done_q <= (state == RUN) && (state_next == DONE);
            if (!run_next) begin
                seg <= '0;
                ptr <= '0;
                cnt <= '0;
            end else if (entry) begin
                seg       <= entry_seg;
                ptr       <= {1'b0, dsc_start[entry_seg], {FRAC{1'b0}}};
                cnt       <= dsc_cycles[entry_seg];
                act_start <= dsc_start[entry_seg];
                act_end   <= dsc_end[entry_seg];
                act_step  <= dsc_step[entry_seg];
            end else if (wrap) begin
                ptr <= {1'b0, act_start, {FRAC{1'b0}}};
                cnt <= cnt - 1'b1;
            end else begin
                ptr <= p_next;
            end
            // Leaving RUN kills every in-flight sample so dac_o drops at once.
            vld_p0 <= (state == RUN) && run_next;
            vld_p1 <= vld_p0 && run_next;
            dac_p2 <= (vld_p1 && run_next) ? sat(sum_p1) : '0;
        end
    end

    always_ff @(posedge dac_clk_i) begin
        if (entry) begin
            act_amp <= dsc_amp[entry_seg];
            act_off <= dsc_off[entry_seg];
        end
        // p0: address on the RAM, gain/offset ride along with it
        amp_p0  <= act_amp;
        off_p0  <= act_off;
        // p1: RAM data scaled by the segment gain
        prod_p1 <= scale(buf_rdata_i, amp_p0);
        off_p1  <= off_p0;
    end

    // p2: offset added and saturated into the DAC register
    assign sum_p1 = SUMW'(prod_p1) + SUMW'(off_p1);

    assign buf_addr_o = ptr[FRAC +: RSZ];
    assign dac_o      = dac_p2;
    assign busy_o     = (state == RUN);
    assign seg_o      = seg;
    assign done_o     = done_q;

endmodule

// File: doc/asg_seq_player.md
Name: asg_seq_player

Overview:
Parametrised multi-segment waveform sequencer for one arbitrary-signal-generator DAC channel. It plays a programmable list of NSEG segments from an external waveform RAM. Each segment has its own table window, fractional step, repeat count, amplitude and DC offset. Segments advance automatically, with optional looping of the whole sequence. It sits between the ASG register bank (config port) and the channel's waveform BRAM (read port), and drives the DAC data path.

Parameters:
NSEG, 4, number of segment descriptors (power of 2, >=2); SW = log2(NSEG)
DAC_DW, 14, sample/DAC width, two's complement
RSZ, 14, waveform RAM address width
FRAC, 16, fractional bits of read pointer and step
CW, 16, per-segment cycle-count width

Ports:
dac_clk_i  in  1  clock
dac_rstn_i  in  1  reset, asynchronous, active-low
arm_i  in  1  pulse: IDLE/DONE -> ARMED
stop_i  in  1  pulse: any state -> IDLE
trig_i  in  1  trigger level; rising edge starts playback
loop_i  in  1  1 = restart at segment 0 after last segment
seq_last_i  in  SW  index of last active segment
cfg_we_i  in  1  descriptor write strobe
cfg_seg_i  in  SW  descriptor index
cfg_field_i  in  3  0 start, 1 end, 2 step, 3 cycles, 4 amp, 5 offset (6,7 ignored)
cfg_data_i  in  32  field value, LSB-aligned
buf_addr_o  out  RSZ  waveform RAM read address
buf_rdata_i  in  DAC_DW  RAM data, valid 1 cycle after address
dac_o  out  DAC_DW  scaled sample
busy_o  out  1  high in RUN
seg_o  out  SW  active segment index
done_o  out  1  one-cycle pulse on entry to DONE

Behaviour:
- Reset: all descriptors 0; state IDLE; dac_o=0, buf_addr_o=0, busy_o=0, seg_o=0, done_o=0; trigger edge detector cleared.
- Descriptor field widths:
  - start, end: RSZ bits.
  - step: RSZ+FRAC bits, with 1<<FRAC = 1 sample.
  - cycles: CW bits.
  - amp: DAC_DW bits unsigned, with 1<<(DAC_DW-1) = 1.0.
  - offset: DAC_DW bits signed.
- Descriptor latching: on segment entry the descriptor is copied into an active copy. Config writes during RUN affect only later entries.
- FSM states: IDLE, ARMED, RUN, DONE.
  - IDLE --arm_i--> ARMED.
  - ARMED --trig rising edge--> RUN: seg=0, ptr = start<<FRAC, cycle counter = cycles.
  - RUN --last cycle of segment seq_last_i, loop_i=0--> DONE with done_o pulse.
  - DONE --arm_i--> ARMED.
  - stop_i --> IDLE from any state.
  - stop_i and trigger in the same cycle: stop wins.
  - Trigger edges in RUN, DONE and IDLE are ignored.
- Pointer in RUN:
  - Pointer width is RSZ+FRAC+1.
  - Each cycle: p_next = ptr + step.
  - If p_next integer part > end, or p_next overflows, the cycle is complete: ptr = start<<FRAC and the fractional residue is discarded.
  - Otherwise ptr = p_next.
  - buf_addr_o = registered integer part of ptr.
- Cycle completion:
  - Decrement the cycle counter on each completed cycle.
  - cycles=0 is treated as 1.
  - When the counter is exhausted, go to the next segment.
  - After segment seq_last_i: go to segment 0 if loop_i=1, else DONE.
  - Segment switch has no dead cycle: the first address of the new segment follows the last address of the old one.
- Degenerate descriptors:
  - end < start: treated as end = start (one sample per cycle).
  - step = 0: the segment holds its start address indefinitely.
- Data path (registered stages):
  - Stage 1 (RAM): address presented at cycle n, buf_rdata_i valid at n+1.
  - Stage 2: product = signed(rdata) × unsigned(amp), arithmetic shift right by DAC_DW-1.
  - Stage 3: sum = product + offset, saturated to [-2^(DAC_DW-1), 2^(DAC_DW-1)-1].
  - dac_o for the address issued at cycle n appears at n+3.
  - amp/offset travel with each sample down the pipe, so segment boundaries scale correctly.
- Outside RUN the pipeline is flushed: dac_o=0 from the cycle after leaving RUN.
- seg_o tracks the segment of the address currently issued.
- busy_o = (state == RUN).

Test Plan:
1. Two-segment playback:
   - Stimulus: seg0 start0 end3 step 0x10000 cycles2; seg1 start16 end17 step 0x8000 cycles1; seq_last=1, loop=0; arm, trig.
   - Required: buf_addr_o = 0,1,2,3,0,1,2,3,16,16,17,17; done_o pulses once; busy_o drops; dac_o=0 afterwards.
2. Scaling and saturation:
   - RAM sample 0x1000, amp 0x2000, offset 0 -> dac_o 4096.
   - Same sample, amp 0x1000, offset -500 -> 1548.
   - Sample 0x1FFF, amp 0x3FFF, offset 0x1FFF -> 0x1FFF (saturated).
   - Sample 0x2000 (-8192), amp 0x3FFF, offset -8192 -> 0x2000.
   - All values appear 3 cycles after their address.
3. Loop mode:
   - Stimulus: as scenario 1 with loop=1.
   - Required: after address 17 the next address is 0 and seg_o=0; no done_o; stop_i -> IDLE and dac_o=0 next cycle.
4. Fractional and overflow step:
   - Stimulus: start 0x3FFE, end 0x3FFF, step 0x18000.
   - Required: addresses 0x3FFE,0x3FFE,0x3FFF?? must not occur: sequence is 0x3FFE, 0x3FFF (ptr 0x3FFF.8), then wrap to 0x3FFE, with no address beyond 0x3FFF.
5. Trigger and stop corner cases:
   - Trigger held high while arming: no start until a new rising edge.
   - stop_i and trig edge in the same cycle: stays IDLE.
   - Second trigger in RUN: ignored.
   - dac_rstn_i low mid-RUN: all outputs 0 immediately.
6. Shadowing:
   - Stimulus: write seg1 amp during seg0 playback.
   - Required: the new amp applies to seg1's first sample. A write to seg0 amp during seg0 does not change the current pass but applies on the next loop.
